pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives per-stage enable and flush strobes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- Detects load-use hazards, taken-branch redirects and data-memory wait.
- Owns the busy timer of the multi-cycle HI/LO multiply/divide unit and stalls dependent or conflicting instructions in ID.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 23 ++
 rtl/md_busy_timer.sv | 55 +++++
 rtl/pipeline_hazard_ctrl.sv | 117 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its mult/div busy timer.
// Register index type, mult/div timer state encoding and default latencies.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_IDX_W = 5;
    typedef logic [REG_IDX_W-1:0] regIdx_t;
    localparam regIdx_t REG_ZERO = '0;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } mdState_t;

    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 32;
    localparam int CNT_W_DEF   = 6;

    // True when an operand is actually read and names the given destination.
    function automatic logic regMatch(input logic uses, input regIdx_t src, input regIdx_t dst);
        return uses && (src == dst);
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Busy timer for the multi-cycle HI/LO multiply/divide unit: busy is high for exactly
// MUL_LAT or DIV_LAT cycles, starting the cycle after a start pulse.
import pipeline_hazard_ctrl_pkg::*;

module md_busy_timer #(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic isDiv,
    output logic busy
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mdState_t         state;
    logic [CNT_W-1:0] mdCnt;

    // busy is kept as a registered copy of (mdCnt != 0): set on load, cleared on the last decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MD_IDLE;
            mdCnt <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        mdCnt <= isDiv ? DIV_LOAD : MUL_LOAD;
                        busy  <= 1'b1;
                        state <= MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    mdCnt <= mdCnt - CNT_ONE;
                    if (mdCnt == CNT_ONE) begin
                        busy  <= 1'b0;
                        state <= MD_IDLE;
                    end
                end
                default: begin
                    state <= MD_IDLE;
                    mdCnt <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (load-use, branch redirect, memory wait, mult/div busy).
// Optional performance counters stallCnt/flushCnt are compiled in with PIPE_PERF_CNT_EN.
import pipeline_hazard_ctrl_pkg::*;

module pipeline_hazard_ctrl #(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  idRs,
    input  logic [4:0]  idRt,
    input  logic        idUsesRs,
    input  logic        idUsesRt,
    input  logic        idIsMulDiv,
    input  logic        idIsDiv,
    input  logic        idReadsHiLo,
    input  logic        exIsLoad,
    input  logic        exRegWrite,
    input  logic [4:0]  exRegDst,
    input  logic        exBranchTaken,
    input  logic        memStall,
    output logic        pcEn,
    output logic        ifIdEn,
    output logic        idExEn,
    output logic        exMemEn,
    output logic        memWbEn,
    output logic        ifIdFlush,
    output logic        idExFlush,
    output logic        mdStart,
    output logic        mdBusy
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] stallCnt,
    output logic [31:0] flushCnt
`endif
);

    logic timerBusy;
    logic loadUse;
    logic mdHaz;

    md_busy_timer #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_md_busy_timer (
        .clk   (clk),
        .rst   (rst),
        .start (mdStart),
        .isDiv (idIsDiv),
        .busy  (timerBusy)
    );

    // $0 is hardwired, so a load targeting it never creates a dependency.
    assign loadUse = exIsLoad && exRegWrite && (exRegDst != REG_ZERO) &&
                     (regMatch(idUsesRs, idRs, exRegDst) || regMatch(idUsesRt, idRt, exRegDst));
    assign mdHaz   = timerBusy && (idIsMulDiv || idReadsHiLo);

    // Priority: reset, memory wait freezes everything, taken branch squashes wrong-path work,
    // then ID hazards insert a bubble; only a clean cycle may start the mult/div unit.
    always_comb begin
        pcEn      = 1'b1;
        ifIdEn    = 1'b1;
        idExEn    = 1'b1;
        exMemEn   = 1'b1;
        memWbEn   = 1'b1;
        ifIdFlush = 1'b0;
        idExFlush = 1'b0;
        mdStart   = 1'b0;
        mdBusy    = timerBusy;
        if (rst) begin
            pcEn      = 1'b0;
            ifIdFlush = 1'b1;
            idExFlush = 1'b1;
            mdBusy    = 1'b0;
        end else if (memStall) begin
            pcEn      = 1'b0;
            ifIdEn    = 1'b0;
            idExEn    = 1'b0;
            exMemEn   = 1'b0;
            memWbEn   = 1'b0;
        end else if (exBranchTaken) begin
            ifIdFlush = 1'b1;
            idExFlush = 1'b1;
        end else if (loadUse || mdHaz) begin
            pcEn      = 1'b0;
            ifIdEn    = 1'b0;
            idExFlush = 1'b1;
        end else begin
            mdStart   = idIsMulDiv;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic stallActive;
    logic flushActive;

    assign stallActive = !rst && !memStall && !exBranchTaken && (loadUse || mdHaz);
    assign flushActive = !rst && !memStall && exBranchTaken;

    // Free-running event counters; they wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (stallActive) stallCnt <= stallCnt + 32'd1;
            if (flushActive) flushCnt <= flushCnt + 32'd1;
        end
    end
`else
    // Counters compiled out; control outputs are unaffected.
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios then random stimulus,
// compared each cycle against a cycle-count reference model of the mult/div unit.
module tb_pipeline_hazard_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic        clk;
    logic        rst;
    logic [4:0]  idRs;
    logic [4:0]  idRt;
    logic        idUsesRs;
    logic        idUsesRt;
    logic        idIsMulDiv;
    logic        idIsDiv;
    logic        idReadsHiLo;
    logic        exIsLoad;
    logic        exRegWrite;
    logic [4:0]  exRegDst;
    logic        exBranchTaken;
    logic        memStall;
    logic        pcEn;
    logic        ifIdEn;
    logic        idExEn;
    logic        exMemEn;
    logic        memWbEn;
    logic        ifIdFlush;
    logic        idExFlush;
    logic        mdStart;
    logic        mdBusy;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stallCnt;
    logic [31:0] flushCnt;
    logic [31:0] modelStalls;
    logic [31:0] modelFlushes;
`endif

    int checks;
    int errors;
    int busyLeft;

    pipeline_hazard_ctrl #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (6)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .idRs          (idRs),
        .idRt          (idRt),
        .idUsesRs      (idUsesRs),
        .idUsesRt      (idUsesRt),
        .idIsMulDiv    (idIsMulDiv),
        .idIsDiv       (idIsDiv),
        .idReadsHiLo   (idReadsHiLo),
        .exIsLoad      (exIsLoad),
        .exRegWrite    (exRegWrite),
        .exRegDst      (exRegDst),
        .exBranchTaken (exBranchTaken),
        .memStall      (memStall),
        .pcEn          (pcEn),
        .ifIdEn        (ifIdEn),
        .idExEn        (idExEn),
        .exMemEn       (exMemEn),
        .memWbEn       (memWbEn),
        .ifIdFlush     (ifIdFlush),
        .idExFlush     (idExFlush),
        .mdStart       (mdStart),
        .mdBusy        (mdBusy)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stallCnt      (stallCnt),
        .flushCnt      (flushCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, observed, expected, $time);
        end
    endtask

    task automatic setIdle();
        rst           = 1'b0;
        idRs          = 5'd0;
        idRt          = 5'd0;
        idUsesRs      = 1'b0;
        idUsesRt      = 1'b0;
        idIsMulDiv    = 1'b0;
        idIsDiv       = 1'b0;
        idReadsHiLo   = 1'b0;
        exIsLoad      = 1'b0;
        exRegWrite    = 1'b0;
        exRegDst      = 5'd0;
        exBranchTaken = 1'b0;
        memStall      = 1'b0;
    endtask

    // Inputs are already driven (1 time unit after a posedge); predict, check, then advance the model.
    task automatic applyStimulus();
        logic       luExp;
        logic       hazExp;
        logic [4:0] enExp;
        logic [1:0] flExp;
        logic       startExp;
        logic       busyExp;
        logic       stallEvt;
        logic       flushEvt;
        luExp    = exIsLoad && exRegWrite && (exRegDst != 5'd0) &&
                   ((idUsesRs && idRs == exRegDst) || (idUsesRt && idRt == exRegDst));
        hazExp   = (busyLeft > 0) && (idIsMulDiv || idReadsHiLo);
        enExp    = 5'b11111;
        flExp    = 2'b00;
        startExp = 1'b0;
        busyExp  = (busyLeft > 0);
        stallEvt = 1'b0;
        flushEvt = 1'b0;
        if (rst) begin
            enExp   = 5'b01111;
            flExp   = 2'b11;
            busyExp = 1'b0;
        end else if (memStall) begin
            enExp = 5'b00000;
        end else if (exBranchTaken) begin
            flExp    = 2'b11;
            flushEvt = 1'b1;
        end else if (luExp || hazExp) begin
            enExp    = 5'b00111;
            flExp    = 2'b01;
            stallEvt = 1'b1;
        end else begin
            startExp = idIsMulDiv;
        end
        #3;
        checkOutput("enables", {27'd0, pcEn, ifIdEn, idExEn, exMemEn, memWbEn}, {27'd0, enExp});
        checkOutput("flushes", {30'd0, ifIdFlush, idExFlush}, {30'd0, flExp});
        checkOutput("mdStart", {31'd0, mdStart}, {31'd0, startExp});
        checkOutput("mdBusy", {31'd0, mdBusy}, {31'd0, busyExp});
`ifdef PIPE_PERF_CNT_EN
        checkOutput("stallCnt", stallCnt, modelStalls);
        checkOutput("flushCnt", flushCnt, modelFlushes);
`endif
        @(posedge clk);
        if (rst) begin
            busyLeft = 0;
        end else begin
            if (busyLeft > 0) busyLeft--;
            if (startExp) busyLeft = idIsDiv ? DIV_LAT : MUL_LAT;
        end
`ifdef PIPE_PERF_CNT_EN
        if (rst) begin
            modelStalls  = 32'd0;
            modelFlushes = 32'd0;
        end else begin
            if (stallEvt) modelStalls  = modelStalls + 32'd1;
            if (flushEvt) modelFlushes = modelFlushes + 32'd1;
        end
`endif
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        busyLeft = 0;
`ifdef PIPE_PERF_CNT_EN
        modelStalls  = 32'd0;
        modelFlushes = 32'd0;
`endif
        setIdle();
        rst = 1'b1;
        repeat (2) applyStimulus();

        // Load-use on rs, then on rt, then a load to $0 which must not stall.
        setIdle();
        exIsLoad = 1'b1; exRegWrite = 1'b1; exRegDst = 5'd8; idRs = 5'd8; idUsesRs = 1'b1;
        applyStimulus();
        idUsesRs = 1'b0; idRt = 5'd8; idUsesRt = 1'b1;
        applyStimulus();
        exRegDst = 5'd0; idRs = 5'd0; idRt = 5'd0; idUsesRs = 1'b1;
        applyStimulus();

        // Taken branch overrides a load-use stall.
        exRegDst = 5'd8; idRs = 5'd8; exBranchTaken = 1'b1;
        applyStimulus();

        // div then mflo waiting in ID until the unit frees up.
        setIdle();
        idIsMulDiv = 1'b1; idIsDiv = 1'b1;
        applyStimulus();
        setIdle();
        idReadsHiLo = 1'b1;
        repeat (DIV_LAT + 2) applyStimulus();

        // mult with the memory stalling for 3 of its 4 busy cycles.
        setIdle();
        idIsMulDiv = 1'b1;
        applyStimulus();
        setIdle();
        memStall = 1'b1;
        repeat (3) applyStimulus();
        memStall = 1'b0;
        repeat (2) applyStimulus();

        // Back-to-back: div then mult held in ID, issuing as soon as busy drops.
        setIdle();
        idIsMulDiv = 1'b1; idIsDiv = 1'b1;
        applyStimulus();
        idIsDiv = 1'b0;
        repeat (DIV_LAT + 2) applyStimulus();

        // Reset five cycles into a divide aborts the timer.
        setIdle();
        idIsMulDiv = 1'b1; idIsDiv = 1'b1;
        applyStimulus();
        setIdle();
        repeat (5) applyStimulus();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        repeat (2) applyStimulus();

        // Two load-use stalls then one taken branch.
        setIdle();
        exIsLoad = 1'b1; exRegWrite = 1'b1; exRegDst = 5'd9; idRt = 5'd9; idUsesRt = 1'b1;
        repeat (2) applyStimulus();
        setIdle();
        exBranchTaken = 1'b1;
        applyStimulus();
        setIdle();
        applyStimulus();

        // Random traffic with small register indices so dependencies are frequent.
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 99) == 0);
            idRs          = 5'($urandom_range(0, 3));
            idRt          = 5'($urandom_range(0, 3));
            idUsesRs      = 1'($urandom_range(0, 1));
            idUsesRt      = 1'($urandom_range(0, 1));
            idIsMulDiv    = ($urandom_range(0, 5) == 0);
            idIsDiv       = ($urandom_range(0, 3) == 0);
            idReadsHiLo   = ($urandom_range(0, 3) == 0);
            exIsLoad      = 1'($urandom_range(0, 1));
            exRegWrite    = ($urandom_range(0, 3) != 0);
            exRegDst      = 5'($urandom_range(0, 3));
            exBranchTaken = ($urandom_range(0, 7) == 0);
            memStall      = ($urandom_range(0, 7) == 0);
            applyStimulus();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
